pe_job_sequencer: RTL and testbench

Sequences one convolution job through a processing element (PE). It captures a job descriptor, loads the filter buffer, streams tagged IFMap rows into the IFMap buffer, pulses the PE start, waits for done, then drains the Psum buffer to a downstream valid/ready port. It sits between the host-side streams and the PE top level, replacing hand-driven wen/start/ren sequencing.

---
 rtl/pe_job_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pe_job_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_job_sequencer.sv
// pe_job_sequencer: sequences one convolution job (filter load, tagged IFMap load, start, Psum drain) through a PE.
// Revision: 1.0
`default_nettype none

module pe_job_sequencer #(
  parameter int IFMAP_WIDTH  = 18,
  parameter int FILTER_WIDTH = 16,
  parameter int PSUM_WIDTH   = 16,
  parameter int CNT_SIZE     = 8,
  parameter int STRIDE_SIZE  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [1:0]               cfg_filter_size,
  input  logic [STRIDE_SIZE-1:0]   cfg_stride,
  input  logic [CNT_SIZE-1:0]      cfg_row_len,
  input  logic [CNT_SIZE-1:0]      cfg_num_rows,
  input  logic [CNT_SIZE-1:0]      cfg_num_psum,
  input  logic                     ifm_valid,
  output logic                     ifm_ready,
  input  logic [IFMAP_WIDTH-3:0]   ifm_data,
  input  logic                     flt_valid,
  output logic                     flt_ready,
  input  logic [FILTER_WIDTH-1:0]  flt_data,
  output logic [IFMAP_WIDTH-1:0]   pe_ifmap_wdata,
  output logic                     pe_wen_ifmap,
  input  logic                     pe_ifmap_full,
  output logic [FILTER_WIDTH-1:0]  pe_filter_wdata,
  output logic                     pe_wen_filter,
  input  logic                     pe_filter_full,
  output logic                     pe_start,
  output logic [STRIDE_SIZE-1:0]   pe_stride,
  output logic [1:0]               pe_filter_size,
  input  logic                     pe_done,
  output logic                     pe_ren_psum,
  input  logic [PSUM_WIDTH-1:0]    pe_psum_rdata,
  output logic                     psum_valid,
  input  logic                     psum_ready,
  output logic [PSUM_WIDTH-1:0]    psum_data,
  output logic                     busy,
  output logic                     job_done,
  output logic                     cfg_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_FLT  = 3'd1,
    LOAD_IFM  = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    DRAIN     = 3'd5
  } state_t;

  localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

  state_t state, state_next;

  logic [1:0]              k_reg;
  logic [STRIDE_SIZE-1:0]  stride_reg;
  logic [CNT_SIZE-1:0]     row_len_reg, num_rows_reg, num_psum_reg;
  logic [3:0]              flt_cnt;
  logic [CNT_SIZE-1:0]     col_cnt, row_cnt, psum_cnt;
  logic                    rd_pend, out_valid;
  logic [PSUM_WIDTH-1:0]   out_data;
  logic                    cfg_err_reg, job_done_reg;

  logic       cfg_zero, cfg_accept;
  logic       flt_hs, ifm_hs, psum_hs;
  logic       flt_last, col_last, ifm_last, psum_last;
  logic [3:0] k_sq;
  logic [1:0] tag;

  assign cfg_zero   = (cfg_filter_size == 2'd0) || (cfg_row_len == '0) ||
                      (cfg_num_rows == '0) || (cfg_num_psum == '0);
  assign cfg_accept = (state == IDLE) && cfg_valid && !cfg_zero;

  assign k_sq     = {2'b00, k_reg} * {2'b00, k_reg};
  assign flt_hs   = (state == LOAD_FLT) && flt_valid && !pe_filter_full;
  assign flt_last = (flt_cnt == k_sq - 4'd1);

  assign ifm_hs   = (state == LOAD_IFM) && ifm_valid && !pe_ifmap_full;
  assign col_last = (col_cnt == row_len_reg - CNT_ONE);
  assign ifm_last = col_last && (row_cnt == num_rows_reg - CNT_ONE);

  // A single-column row is both first and last, hence 2'b11.
  always_comb begin
    tag = 2'b00;
    if (row_len_reg == CNT_ONE) tag = 2'b11;
    else if (col_cnt == '0)     tag = 2'b10;
    else if (col_last)          tag = 2'b01;
  end

  // Read data is presented straight from the PE in its valid cycle and only
  // captured if downstream stalls, giving valid two cycles after pe_done.
  assign psum_valid = (state == DRAIN) && (rd_pend || out_valid);
  assign psum_data  = rd_pend ? pe_psum_rdata : out_data;
  assign psum_hs    = psum_valid && psum_ready;
  assign psum_last  = (psum_cnt == num_psum_reg - CNT_ONE);

  assign pe_wen_filter   = flt_hs;
  assign pe_filter_wdata = flt_hs ? flt_data : '0;
  assign pe_wen_ifmap    = ifm_hs;
  assign pe_ifmap_wdata  = ifm_hs ? {tag, ifm_data} : '0;
  assign pe_stride       = stride_reg;
  assign pe_filter_size  = k_reg;
  assign cfg_err         = cfg_err_reg;
  assign job_done        = job_done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cfg_ready   = 1'b0;
    flt_ready   = 1'b0;
    ifm_ready   = 1'b0;
    pe_start    = 1'b0;
    pe_ren_psum = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_accept) state_next = LOAD_FLT;
      end
      LOAD_FLT: begin
        flt_ready = !pe_filter_full;
        if (flt_hs && flt_last) state_next = LOAD_IFM;
      end
      LOAD_IFM: begin
        ifm_ready = !pe_ifmap_full;
        if (ifm_hs && ifm_last) state_next = START;
      end
      START: begin
        pe_start   = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (pe_done) state_next = DRAIN;
      end
      DRAIN: begin
        pe_ren_psum = !out_valid && !rd_pend && (psum_cnt != num_psum_reg);
        if (psum_hs && psum_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg        <= '0;
      stride_reg   <= '0;
      row_len_reg  <= '0;
      num_rows_reg <= '0;
      num_psum_reg <= '0;
      flt_cnt      <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      psum_cnt     <= '0;
      rd_pend      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      cfg_err_reg  <= 1'b0;
      job_done_reg <= 1'b0;
    end else begin
      cfg_err_reg  <= (state == IDLE) && cfg_valid && cfg_zero;
      job_done_reg <= (state == DRAIN) && psum_hs && psum_last;

      if (cfg_accept) begin
        k_reg        <= cfg_filter_size;
        stride_reg   <= cfg_stride;
        row_len_reg  <= cfg_row_len;
        num_rows_reg <= cfg_num_rows;
        num_psum_reg <= cfg_num_psum;
        flt_cnt      <= '0;
        col_cnt      <= '0;
        row_cnt      <= '0;
        psum_cnt     <= '0;
      end

      if (flt_hs) flt_cnt <= flt_last ? 4'd0 : flt_cnt + 4'd1;

      if (ifm_hs) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= ifm_last ? '0 : row_cnt + CNT_ONE;
        end else begin
          col_cnt <= col_cnt + CNT_ONE;
        end
      end

      rd_pend <= pe_ren_psum;
      if (rd_pend) begin
        out_data  <= pe_psum_rdata;
        out_valid <= !psum_ready;
      end else if (out_valid && psum_ready) begin
        out_valid <= 1'b0;
      end

      if (psum_hs) psum_cnt <= psum_last ? '0 : psum_cnt + CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_job_sequencer.sv
// tb_pe_job_sequencer: scoreboard bench for pe_job_sequencer with a 1-cycle-latency PE psum model.
`default_nettype none

module tb_pe_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_filter_size;
  logic [2:0]  cfg_stride;
  logic [7:0]  cfg_row_len, cfg_num_rows, cfg_num_psum;
  logic        ifm_valid, ifm_ready;
  logic [15:0] ifm_data;
  logic        flt_valid, flt_ready;
  logic [15:0] flt_data;
  logic [17:0] pe_ifmap_wdata;
  logic        pe_wen_ifmap, pe_ifmap_full;
  logic [15:0] pe_filter_wdata;
  logic        pe_wen_filter, pe_filter_full;
  logic        pe_start;
  logic [2:0]  pe_stride;
  logic [1:0]  pe_filter_size;
  logic        pe_done, pe_ren_psum;
  logic [15:0] pe_psum_rdata;
  logic        psum_valid, psum_ready;
  logic [15:0] psum_data;
  logic        busy, job_done, cfg_err;

  pe_job_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_filter_size(cfg_filter_size), .cfg_stride(cfg_stride),
    .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows), .cfg_num_psum(cfg_num_psum),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
    .pe_ifmap_wdata(pe_ifmap_wdata), .pe_wen_ifmap(pe_wen_ifmap), .pe_ifmap_full(pe_ifmap_full),
    .pe_filter_wdata(pe_filter_wdata), .pe_wen_filter(pe_wen_filter), .pe_filter_full(pe_filter_full),
    .pe_start(pe_start), .pe_stride(pe_stride), .pe_filter_size(pe_filter_size), .pe_done(pe_done),
    .pe_ren_psum(pe_ren_psum), .pe_psum_rdata(pe_psum_rdata),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .busy(busy), .job_done(job_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  logic [15:0] flt_q[$];
  logic [17:0] ifm_q[$];
  logic [15:0] ps_q[$];
  logic [15:0] pe_mem[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // PE psum buffer: data appears the cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    logic [15:0] rd;
    if (pe_ren_psum) begin
      rd = (pe_mem.size() > 0) ? pe_mem.pop_front() : 16'hBAD0;
      pe_psum_rdata <= rd;
    end else begin
      pe_psum_rdata <= 16'hDEAD;
    end
  end

  logic        hold_chk = 1'b0;
  logic [15:0] held;

  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (pe_wen_filter) begin
        if (flt_q.size() == 0) check("flt_unexpected_write", 1, 0);
        else begin e = 18'(flt_q.pop_front()); check("flt_data", 32'(pe_filter_wdata), 32'(e)); end
      end
      if (pe_wen_ifmap) begin
        if (ifm_q.size() == 0) check("ifm_unexpected_write", 1, 0);
        else begin e = ifm_q.pop_front(); check("ifm_tagged_data", 32'(pe_ifmap_wdata), 32'(e)); end
      end
      if (psum_valid && hold_chk) check("psum_hold", 32'(psum_data), 32'(held));
      if (psum_valid && psum_ready) begin
        if (ps_q.size() == 0) check("psum_unexpected", 1, 0);
        else begin e = 18'(ps_q.pop_front()); check("psum_data", 32'(psum_data), 32'(e)); end
        hold_chk = 1'b0;
      end else if (psum_valid) begin
        hold_chk = 1'b1;
        held     = psum_data;
      end else begin
        hold_chk = 1'b0;
      end
      if (pe_start) n_start++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [1:0] k, input logic [2:0] s, input logic [7:0] rl,
                          input logic [7:0] nr, input logic [7:0] np);
    cfg_filter_size = k; cfg_stride = s; cfg_row_len = rl; cfg_num_rows = nr; cfg_num_psum = np;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic feed_flt(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      logic hs;
      int to;
      w = 16'($urandom);
      flt_q.push_back(w);
      flt_data = w; flt_valid = 1'b1;
      to = 0;
      do begin
        @(negedge clk); hs = flt_ready; tick(); to++;
      end while (!hs && to < 50);
      if (!hs) check("flt_timeout", 0, 1);
    end
    flt_valid = 1'b0;
  endtask

  task automatic feed_ifm(input int rl, input int nr, input bit bp, input bit early);
    for (int i = 0; i < rl * nr; i++) begin
      logic [15:0] d;
      logic [1:0]  t;
      logic hs;
      int col, to;
      col = i % rl;
      t = (rl == 1) ? 2'b11 : (col == 0) ? 2'b10 : (col == rl - 1) ? 2'b01 : 2'b00;
      d = 16'($urandom);
      ifm_q.push_back({t, d});
      ifm_data = d; ifm_valid = 1'b1;
      pe_done = early && (i == 1);
      if (bp && i == 3) begin
        pe_ifmap_full = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("ifm_ready_when_full", 32'(ifm_ready), 0);
          check("ifm_wen_when_full", 32'(pe_wen_ifmap), 0);
          tick();
        end
        pe_ifmap_full = 1'b0;
      end
      to = 0;
      do begin
        @(negedge clk); hs = ifm_ready; tick(); to++;
      end while (!hs && to < 50);
      if (!hs) check("ifm_timeout", 0, 1);
      pe_done = 1'b0;
    end
    ifm_valid = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] k, input logic [2:0] s, input int rl, input int nr,
                         input int np, input bit ifm_bp, input bit ps_bp, input bit early);
    int starts0;
    bit got;
    starts0 = n_start;
    for (int i = 0; i < np; i++) begin
      logic [15:0] p;
      p = 16'($urandom);
      pe_mem.push_back(p);
      ps_q.push_back(p);
    end
    psum_ready = 1'b1;
    send_cfg(k, s, 8'(rl), 8'(nr), 8'(np));
    feed_flt(int'(k) * int'(k));
    feed_ifm(rl, nr, ifm_bp, early);
    @(negedge clk);
    check("start_after_last_ifm", 32'(pe_start), 1);
    check("pe_stride", 32'(pe_stride), 32'(s));
    check("pe_filter_size", 32'(pe_filter_size), 32'(k));
    tick();
    repeat (3) begin
      @(negedge clk);
      check("no_ren_before_done", 32'(pe_ren_psum), 0);
      check("busy_wait_done", 32'(busy), 1);
      tick();
    end
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    @(negedge clk);
    check("ren_at_done_plus1", 32'(pe_ren_psum), 1);
    tick();
    @(negedge clk);
    check("valid_at_done_plus2", 32'(psum_valid), 1);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick();
      psum_ready = ps_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      got = job_done;
    end
    check("job_done_seen", 32'(got), 1);
    check("busy_after_job", 32'(busy), 0);
    tick();
    @(negedge clk);
    check("job_done_one_cycle", 32'(job_done), 0);
    check("start_pulse_count", 32'(n_start - starts0), 1);
    check("flt_q_empty", 32'(flt_q.size()), 0);
    check("ifm_q_empty", 32'(ifm_q.size()), 0);
    check("psum_q_empty", 32'(ps_q.size()), 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 0; cfg_filter_size = 0; cfg_stride = 0; cfg_row_len = 0; cfg_num_rows = 0; cfg_num_psum = 0;
    ifm_valid = 0; ifm_data = 0; flt_valid = 0; flt_data = 0;
    pe_ifmap_full = 0; pe_filter_full = 0; pe_done = 0; psum_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_outputs", {psum_valid, pe_ren_psum, pe_start, pe_wen_filter, pe_wen_ifmap,
                          flt_ready, ifm_ready, job_done, cfg_err}, 0);
    check("rst_stride_k", {pe_stride, pe_filter_size}, 0);
    rst = 1'b0;
    tick();

    send_cfg(2'd3, 3'd1, 8'd0, 8'd2, 8'd1);
    @(negedge clk);
    check("zero_field_cfg_err", 32'(cfg_err), 1);
    check("zero_field_idle", 32'(busy), 0);
    tick();
    @(negedge clk);
    check("cfg_err_one_cycle", 32'(cfg_err), 0);
    check("zero_field_cfg_ready", 32'(cfg_ready), 1);
    tick();

    run_job(2'd3, 3'd2, 7, 2, 3, 1'b0, 1'b0, 1'b0);
    run_job(2'd2, 3'd1, 6, 2, 5, 1'b1, 1'b1, 1'b0);
    run_job(2'd1, 3'd4, 1, 3, 2, 1'b0, 1'b0, 1'b1);

    // Abort in DRAIN with a stalled output, then accept a fresh job.
    pe_mem.push_back(16'h1234);
    ps_q.push_back(16'h1234);
    psum_ready = 1'b0;
    send_cfg(2'd1, 3'd5, 8'd1, 8'd1, 8'd1);
    feed_flt(1);
    feed_ifm(1, 1, 1'b0, 1'b0);
    tick();
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("drain_stalled_valid", 32'(psum_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_psum_valid", 32'(psum_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_cfg_ready", 32'(cfg_ready), 1);
    check("async_rst_stride_k", {pe_stride, pe_filter_size}, 0);
    ps_q.delete();
    pe_mem.delete();
    tick();
    rst = 1'b0;
    tick();
    run_job(2'd3, 3'd3, 4, 2, 2, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
